// File: rtl/bist_signature_checker.sv
// Response compactor for the BIST scan chain: folds each unloaded scan window
// into a MISR and, after the configured number of windows, compares the
// signature against a golden value to produce a sticky pass/fail verdict.
module bist_signature_checker #(
    parameter int                   CHAIN_LEN  = 8,
    parameter int                   PATTERNS   = 8,
    parameter int                   SKIP_FIRST = 1,
    parameter int                   SIG_WIDTH  = 8,
    parameter logic [SIG_WIDTH-1:0] POLY       = 8'h1D,
    parameter logic [SIG_WIDTH-1:0] SEED       = 8'h00,
    parameter logic [SIG_WIDTH-1:0] GOLDEN     = 8'h00
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              scan_en,
    input  logic                              scan_data,
    output logic [SIG_WIDTH-1:0]              signature,
    output logic [$clog2(PATTERNS+2)-1:0]     pattern_cnt,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic                              shift_error
);

    localparam int PCNT_W = $clog2(PATTERNS + 2);
    localparam int BIT_W  = $clog2(CHAIN_LEN + 1);

    // Number of windows (including the discarded one) that ends the run.
    localparam logic [PCNT_W-1:0] LAST_PCNT = PCNT_W'(PATTERNS + SKIP_FIRST);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state, state_next;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_next;
    logic [SIG_WIDTH-1:0]  sig_next;
    logic [PCNT_W-1:0]     pcnt_next;
    logic                  done_next;
    logic                  pass_next;
    logic                  err_next;
    logic                  fold_en;

    // One MISR step: shift left, apply feedback taps on MSB, inject serial bit.
    function automatic logic [SIG_WIDTH-1:0] misr_step(
        input logic [SIG_WIDTH-1:0] sig,
        input logic                 din
    );
        logic [SIG_WIDTH-1:0] fb;
        fb = sig[SIG_WIDTH-1] ? POLY : '0;
        return (sig << 1) ^ fb ^ {{(SIG_WIDTH-1){1'b0}}, din};
    endfunction

    // The first window after reset/clear holds stale chain contents; it is
    // counted but kept out of the signature.
    assign fold_en = !((SKIP_FIRST != 0) && (pattern_cnt == '0));

    assign busy = (state == SHIFT) || (state == HOLD);

    // State register and all checker state; async reset, sync clear via next-state logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            signature   <= SEED;
            pattern_cnt <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            shift_error <= 1'b0;
        end else begin
            state       <= state_next;
            bit_cnt     <= bit_cnt_next;
            signature   <= sig_next;
            pattern_cnt <= pcnt_next;
            done        <= done_next;
            pass        <= pass_next;
            shift_error <= err_next;
        end
    end

    // Next-state, MISR fold, window accounting and verdict.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        sig_next     = signature;
        pcnt_next    = pattern_cnt;
        done_next    = done;
        pass_next    = pass;
        err_next     = shift_error;

        if (clear) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
            sig_next     = SEED;
            pcnt_next    = '0;
            done_next    = 1'b0;
            pass_next    = 1'b0;
            err_next     = 1'b0;
        end else begin
            case (state)
                IDLE, SHIFT: begin
                    if (scan_en) begin
                        if (fold_en) begin
                            sig_next = misr_step(signature, scan_data);
                        end
                        if (bit_cnt == LAST_BIT) begin
                            // Window complete: the verdict uses the just-folded signature.
                            bit_cnt_next = '0;
                            if (pattern_cnt < LAST_PCNT) begin
                                pcnt_next = pattern_cnt + 1'b1;
                            end
                            if (pcnt_next == LAST_PCNT) begin
                                state_next = DONE;
                                done_next  = 1'b1;
                                pass_next  = (sig_next == GOLDEN) && !shift_error;
                            end else begin
                                state_next = HOLD;
                            end
                        end else begin
                            bit_cnt_next = bit_cnt + 1'b1;
                            state_next   = SHIFT;
                        end
                    end else if (state == SHIFT) begin
                        // Window truncated by a capture; folded bits stay in the MISR.
                        err_next     = 1'b1;
                        bit_cnt_next = '0;
                        state_next   = IDLE;
                    end
                end
                HOLD: begin
                    if (scan_en) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_signature_checker.sv
// Bench for bist_signature_checker: directed scenarios plus randomized scan
// traffic, compared against a window-level reference model. Two instances
// share stimulus and differ only in GOLDEN, so matching and mismatching
// verdicts are exercised together.
module tb_bist_signature_checker;

    localparam int PAT    = 2;
    localparam int TOTAL  = PAT + 1;
    localparam int CLEN   = 8;
    localparam int GOLD_A = 8'h26;
    localparam int GOLD_B = 8'h27;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       scan_en = 1'b0;
    logic       scan_data = 1'b0;

    logic [7:0] signature_a, signature_b;
    logic [1:0] pattern_cnt_a, pattern_cnt_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b, err_a, err_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_sig;
    int m_pcnt;
    int m_bits;
    bit m_await;
    bit m_err;
    bit m_done;
    bit m_pass_a;
    bit m_pass_b;

    bist_signature_checker #(
        .CHAIN_LEN(CLEN), .PATTERNS(PAT), .SKIP_FIRST(1), .SIG_WIDTH(8),
        .POLY(8'h1D), .SEED(8'h00), .GOLDEN(8'h26)
    ) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .scan_en(scan_en), .scan_data(scan_data),
        .signature(signature_a), .pattern_cnt(pattern_cnt_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .shift_error(err_a)
    );

    bist_signature_checker #(
        .CHAIN_LEN(CLEN), .PATTERNS(PAT), .SKIP_FIRST(1), .SIG_WIDTH(8),
        .POLY(8'h1D), .SEED(8'h00), .GOLDEN(8'h27)
    ) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .scan_en(scan_en), .scan_data(scan_data),
        .signature(signature_b), .pattern_cnt(pattern_cnt_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .shift_error(err_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Polynomial division step over GF(2): append bit, reduce by x^8+x^4+x^3+x^2+1.
    function automatic int ref_fold(input int s, input bit d);
        int t;
        t = (s << 1) | int'(d);
        if (t & 'h100) t = t ^ 'h11D;
        return t & 'hFF;
    endfunction

    task automatic model_reset();
        m_sig = 0; m_pcnt = 0; m_bits = 0;
        m_await = 0; m_err = 0; m_done = 0; m_pass_a = 0; m_pass_b = 0;
    endtask

    task automatic model_step(input bit en, input bit d, input bit clr);
        if (clr) begin
            model_reset();
        end else if (m_done) begin
            // run is over; inputs ignored
        end else if (en) begin
            if (m_await) begin
                m_err = 1;
            end else begin
                if (m_pcnt != 0) m_sig = ref_fold(m_sig, d);
                m_bits++;
                if (m_bits == CLEN) begin
                    m_bits = 0;
                    m_pcnt++;
                    if (m_pcnt == TOTAL) begin
                        m_done   = 1;
                        m_pass_a = (m_sig == GOLD_A) && !m_err;
                        m_pass_b = (m_sig == GOLD_B) && !m_err;
                    end else begin
                        m_await = 1;
                    end
                end
            end
        end else begin
            m_await = 0;
            if (m_bits != 0) begin
                m_err  = 1;
                m_bits = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        bit m_busy;
        m_busy = !m_done && (m_await || m_bits != 0);
        chk({tag, ".sig"},   int'(signature_a),   m_sig);
        chk({tag, ".pcnt"},  int'(pattern_cnt_a), m_pcnt);
        chk({tag, ".busy"},  int'(busy_a),        int'(m_busy));
        chk({tag, ".done"},  int'(done_a),        int'(m_done));
        chk({tag, ".pass"},  int'(pass_a),        int'(m_pass_a));
        chk({tag, ".err"},   int'(err_a),         int'(m_err));
        chk({tag, ".sig_b"}, int'(signature_b),   m_sig);
        chk({tag, ".done_b"},int'(done_b),        int'(m_done));
        chk({tag, ".pass_b"},int'(pass_b),        int'(m_pass_b));
    endtask

    task automatic cyc(input bit en, input bit d, input bit clr, input string tag);
        @(negedge clk);
        scan_en = en; scan_data = d; clear = clr;
        @(posedge clk);
        model_step(en, d, clr);
        #1;
        check_all(tag);
    endtask

    task automatic window(input logic [7:0] b, input string tag);
        for (int i = 7; i >= 0; i--) cyc(1'b1, b[i], 1'b0, tag);
    endtask

    task automatic capture(input string tag);
        cyc(1'b0, 1'b0, 1'b0, tag);
    endtask

    // Reset asserted away from any clock edge; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        rst = 1'b0; scan_en = 1'b0; clear = 1'b0; scan_data = 1'b0;
    endtask

    initial begin
        int r;
        int n;

        async_reset("reset");
        chk("reset.sig_const", int'(signature_a), 0);

        // Golden run: skipped window, 0x80, zeros
        window(8'($urandom), "skipwin");
        capture("cap1");
        window(8'h80, "w2");
        chk("w2.sig_const", int'(signature_a), 'h80);
        capture("cap2");
        window(8'h00, "w3");
        chk("final.sig_const", int'(signature_a), 'h26);
        chk("final.done_const", int'(done_a), 1);
        chk("final.pass_a_const", int'(pass_a), 1);
        chk("final.pass_b_const", int'(pass_b), 0);
        chk("final.pcnt_const", int'(pattern_cnt_a), 3);

        // Frozen in DONE
        repeat (20) cyc(1'($urandom), 1'($urandom), 1'b0, "frozen");
        chk("frozen.sig_const", int'(signature_a), 'h26);

        // Clear wins over scan_en
        cyc(1'b1, 1'b1, 1'b1, "clear");
        chk("clear.pcnt_const", int'(pattern_cnt_a), 0);

        // Truncated counted window
        window(8'($urandom), "e.skip");
        capture("e.cap");
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'($urandom), 1'b0, "e.part");
        cyc(1'b0, 1'b0, 1'b0, "e.drop");
        chk("e.err_const", int'(err_a), 1);
        chk("e.pcnt_const", int'(pattern_cnt_a), 1);
        window(8'h80, "e.w2");
        capture("e.cap2");
        window(8'h00, "e.w3");
        chk("e.pass_const", int'(pass_a), 0);

        // Ninth consecutive bit lands in HOLD
        cyc(1'b0, 1'b0, 1'b1, "n.clear");
        window(8'($urandom), "n.skip");
        capture("n.cap");
        window(8'h80, "n.w2");
        cyc(1'b1, 1'b1, 1'b0, "n.ninth");
        chk("n.sig_const", int'(signature_a), 'h80);
        chk("n.err_const", int'(err_a), 1);
        capture("n.cap2");
        window(8'h00, "n.w3");

        // Reset mid window 2, then clean replay
        cyc(1'b0, 1'b0, 1'b1, "r.clear");
        window(8'($urandom), "r.skip");
        capture("r.cap");
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'($urandom), 1'b0, "r.part");
        async_reset("r.rst");
        window(8'($urandom), "r2.skip");
        capture("r2.cap");
        window(8'h80, "r2.w2");
        capture("r2.cap2");
        window(8'h00, "r2.w3");
        chk("r2.pass_const", int'(pass_a), 1);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 99);
            if (r < 65) begin
                window(8'($urandom), "rnd.win");
                n = $urandom_range(1, 2);
                for (int k = 0; k < n; k++) capture("rnd.cap");
            end else if (r < 77) begin
                n = $urandom_range(1, 7);
                for (int k = 0; k < n; k++) cyc(1'b1, 1'($urandom), 1'b0, "rnd.short");
                capture("rnd.scap");
            end else if (r < 87) begin
                n = $urandom_range(9, 11);
                for (int k = 0; k < n; k++) cyc(1'b1, 1'($urandom), 1'b0, "rnd.long");
                capture("rnd.lcap");
            end else if (r < 95) begin
                cyc(1'($urandom), 1'($urandom), 1'b1, "rnd.clear");
            end else begin
                async_reset("rnd.rst");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
